// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: samples an incoming VGA stream, recovers per-pixel
// coordinates, line/frame start markers and measured line/frame totals, and
// tracks lock against the expected active geometry.
module vga_sync_decoder #(
    parameter int ACTI_H      = 640,
    parameter int ACTI_V      = 480,
    parameter int CW          = 11,
    parameter int LOCK_FRAMES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hs_in,
    input  logic          vs_in,
    input  logic          blank_n_in,
    input  logic [7:0]    r_in,
    input  logic [7:0]    g_in,
    input  logic [7:0]    b_in,
    output logic          pix_valid,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic [7:0]    pix_r,
    output logic [7:0]    pix_g,
    output logic [7:0]    pix_b,
    output logic          line_start,
    output logic          frame_start,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] v_total,
    output logic          locked,
    output logic          err
);

    localparam logic [CW-1:0] CMAX    = '1;
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] ACT_H_C = CW'(ACTI_H);
    localparam logic [CW-1:0] ACT_V_C = CW'(ACTI_V);
    localparam int            MW      = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [MW-1:0] LF_C    = MW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_UNLOCK = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // previous-sample registers for edge detection
    logic          hs_q, vs_q, blank_q;
    // measurement state
    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] vcnt_q, vcnt_d;
    logic [CW-1:0] h_total_q, h_total_d;
    logic [CW-1:0] v_total_q, v_total_d;
    logic [CW-1:0] h_ref_q, h_ref_d;
    logic          ref_ok_q, ref_ok_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          line_bad_q, line_bad_d;
    logic          frame_bad_q, frame_bad_d;
    // lock FSM
    state_t        state_q, state_d;
    logic [MW-1:0] match_q, match_d;
    // registered outputs
    logic          pix_valid_q, pix_valid_d;
    logic [CW-1:0] pix_x_q, pix_x_d;
    logic [CW-1:0] pix_y_q, pix_y_d;
    logic [23:0]   pix_rgb_q, pix_rgb_d;
    logic          line_start_q, frame_start_q;
    logic          locked_q, locked_d;
    logic          err_q, err_d;

    // combinational helpers
    logic          hs_fall, vs_fall, bl_fall, hcnt_sat;
    logic [CW-1:0] cur_x, cur_y, vcnt_inc, lines_now;
    logic          in_win, frame_bad_now, frame_good;

    // Edge detection against the previous sample.
    assign hs_fall  = hs_q & ~hs_in;
    assign vs_fall  = vs_q & ~vs_in;
    assign bl_fall  = blank_q & ~blank_n_in;
    assign hcnt_sat = (hcnt_q == CMAX);

    // Counters, coordinates, totals and per-frame quality judgement.
    always_comb begin
        hcnt_d      = hcnt_q;
        h_total_d   = h_total_q;
        vcnt_inc    = vcnt_q;
        vcnt_d      = vcnt_q;
        v_total_d   = v_total_q;
        h_ref_d     = h_ref_q;
        ref_ok_d    = ref_ok_q;
        x_d         = x_q;
        y_d         = y_q;
        line_bad_d  = line_bad_q;
        frame_bad_d = frame_bad_q;

        // Line length: hcnt restarts at 1 on each HS fall so the total
        // equals the number of clocks between falls.
        if (hs_fall) begin
            hcnt_d    = ONE;
            h_total_d = hcnt_q;
        end else if (!hcnt_sat) begin
            hcnt_d = hcnt_q + ONE;
        end

        // Frame height: the HS update of this cycle is applied before the
        // VS clear so a coincident line is counted in the closing frame.
        if (hs_fall && vcnt_q != CMAX) begin
            vcnt_inc = vcnt_q + ONE;
        end
        vcnt_d = vcnt_inc;
        if (vs_fall) begin
            v_total_d = vcnt_inc;
            vcnt_d    = '0;
        end

        // Coordinate of the pixel sampled this cycle.
        cur_x  = hs_fall ? '0 : x_q;
        cur_y  = vs_fall ? '0 : y_q;
        in_win = (cur_x < ACT_H_C) && (cur_y < ACT_V_C);

        x_d = cur_x;
        if (blank_n_in && cur_x != CMAX) begin
            x_d = cur_x + ONE;
        end
        if (vs_fall) begin
            y_d = '0;
        end else if (bl_fall && y_q != CMAX) begin
            y_d = y_q + ONE;
        end

        if (hs_fall) begin
            line_bad_d = 1'b0;
        end
        if (blank_n_in && !in_win) begin
            line_bad_d = 1'b1;
        end

        // At the end of the active part of a line, x_q holds its pixel count.
        frame_bad_now = frame_bad_q | (bl_fall & (line_bad_q | (x_q != ACT_H_C)));
        lines_now     = y_q + {{(CW-1){1'b0}}, bl_fall};

        // The first judged frame after acquisition only establishes the
        // reference totals; later frames must reproduce them.
        frame_good = ~frame_bad_now
                   & (lines_now == ACT_V_C)
                   & (~ref_ok_q | ((h_total_d == h_ref_q) & (v_total_d == v_total_q)));

        frame_bad_d = vs_fall ? 1'b0 : frame_bad_now;
        if (vs_fall) begin
            h_ref_d  = h_total_d;
            ref_ok_d = (state_q != ST_UNLOCK);
        end
    end

    // Registered pixel path; colour is forced to zero outside valid pixels.
    always_comb begin
        pix_valid_d = blank_n_in & in_win & (state_q != ST_UNLOCK);
        pix_x_d     = cur_x;
        pix_y_d     = cur_y;
        pix_rgb_d   = pix_valid_d ? {r_in, g_in, b_in} : 24'h0;
    end

    // Lock FSM next state; judged at every VS fall, dropped on lost HS.
    always_comb begin
        state_d = state_q;
        match_d = match_q;
        err_d   = 1'b0;
        if (hcnt_sat && !hs_fall) begin
            state_d = ST_UNLOCK;
            match_d = '0;
        end else if (vs_fall) begin
            case (state_q)
                ST_UNLOCK: begin
                    state_d = ST_ACQ;
                    match_d = '0;
                end
                ST_ACQ: begin
                    if (frame_good) begin
                        match_d = match_q + 1'b1;
                        if ((match_q + 1'b1) >= LF_C) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!frame_good) begin
                        err_d   = 1'b1;
                        state_d = ST_ACQ;
                        match_d = '0;
                    end
                end
                default: begin
                    state_d = ST_UNLOCK;
                    match_d = '0;
                end
            endcase
        end
        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_q       <= 1'b0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            h_total_q     <= '0;
            v_total_q     <= '0;
            h_ref_q       <= '0;
            ref_ok_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_bad_q    <= 1'b0;
            frame_bad_q   <= 1'b0;
            state_q       <= ST_UNLOCK;
            match_q       <= '0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_rgb_q     <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            hs_q          <= hs_in;
            vs_q          <= vs_in;
            blank_q       <= blank_n_in;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            h_total_q     <= h_total_d;
            v_total_q     <= v_total_d;
            h_ref_q       <= h_ref_d;
            ref_ok_q      <= ref_ok_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_bad_q    <= line_bad_d;
            frame_bad_q   <= frame_bad_d;
            state_q       <= state_d;
            match_q       <= match_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_rgb_q     <= pix_rgb_d;
            line_start_q  <= hs_fall;
            frame_start_q <= vs_fall;
            locked_q      <= locked_d;
            err_q         <= err_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_r       = pix_rgb_q[23:16];
    assign pix_g       = pix_rgb_q[15:8];
    assign pix_b       = pix_rgb_q[7:0];
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign h_total     = h_total_q;
    assign v_total     = v_total_q;
    assign locked      = locked_q;
    assign err         = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a reduced geometry (16x6 active, 24x10 total).
module tb_vga_sync_decoder;

    localparam int ACT_H   = 16;
    localparam int ACT_V   = 6;
    localparam int CW      = 8;
    localparam int LF      = 2;
    localparam int H_TOT   = 24;
    localparam int HS_ST   = 19;
    localparam int HS_LEN  = 3;
    localparam int V_TOT   = 10;
    localparam int VS_LINE = 7;
    localparam int VS_LEN  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hs_in = 1'b1;
    logic          vs_in = 1'b1;
    logic          blank_n_in = 1'b0;
    logic [7:0]    r_in = 8'h0;
    logic [7:0]    g_in = 8'h0;
    logic [7:0]    b_in = 8'h0;
    logic          pix_valid;
    logic [CW-1:0] pix_x, pix_y;
    logic [7:0]    pix_r, pix_g, pix_b;
    logic          line_start, frame_start;
    logic [CW-1:0] h_total, v_total;
    logic          locked, err;

    vga_sync_decoder #(
        .ACTI_H(ACT_H), .ACTI_V(ACT_V), .CW(CW), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .rst(rst), .hs_in(hs_in), .vs_in(vs_in), .blank_n_in(blank_n_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .line_start(line_start), .frame_start(frame_start),
        .h_total(h_total), .v_total(v_total), .locked(locked), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [23:0]   rgb;
    } pix_t;

    pix_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   err_seen = 0;
    logic m_hs = 1'b1;
    logic m_vs = 1'b1;
    bit   synced = 1'b0;
    bit   exp_ls = 1'b0;
    bit   exp_fs = 1'b0;
    bit   exp_rst = 1'b1;
    bit   vs_align = 1'b0;
    int   frame_no = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [23:0] pix_color(input int x, input int y);
        logic [7:0] r, g, b;
        r = 8'(x * 7 + y * 3 + 1);
        g = 8'(x ^ (y << 4));
        b = 8'(x + y + frame_no * 5 + 9);
        return {r, g, b};
    endfunction

    // Compare DUT outputs (produced by the previous rising edge) to expectations.
    task automatic sample();
        pix_t e;
        if (err === 1'b1) err_seen++;
        if (exp_rst) begin
            check("rst_pix", 32'({pix_valid, pix_x, pix_y}), 32'(0));
            check("rst_rgb", 32'({pix_r, pix_g, pix_b}), 32'(0));
            check("rst_totals", 32'({h_total, v_total}), 32'(0));
            check("rst_flags", 32'({line_start, frame_start, locked, err}), 32'(0));
        end else begin
            check("line_start", 32'(line_start), 32'(exp_ls));
            check("frame_start", 32'(frame_start), 32'(exp_fs));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pix_valid", 32'(pix_valid), 32'(1));
                check("pix_xy", 32'({pix_x, pix_y}), 32'({e.x, e.y}));
                check("pix_rgb", 32'({pix_r, pix_g, pix_b}), 32'(e.rgb));
            end else begin
                check("pix_valid", 32'(pix_valid), 32'(0));
                check("rgb_zero", 32'({pix_r, pix_g, pix_b}), 32'(0));
            end
        end
    endtask

    // One pixel clock: sample, then drive new inputs and record expectations.
    task automatic tick(input logic hs, input logic vs, input logic bl,
                        input int x, input int y, input logic rs);
        pix_t e;
        @(negedge clk);
        sample();
        rst        = rs;
        hs_in      = hs;
        vs_in      = vs;
        blank_n_in = bl;
        {r_in, g_in, b_in} = pix_color(x, y);
        exp_rst = rs;
        exp_ls  = !rs && m_hs && !hs;
        exp_fs  = !rs && m_vs && !vs;
        if (!rs && bl && synced && x < ACT_H && y < ACT_V) begin
            e.x   = CW'(x);
            e.y   = CW'(y);
            e.rgb = pix_color(x, y);
            exp_q.push_back(e);
        end
        if (rs) begin
            synced = 1'b0;
            m_hs   = 1'b1;
            m_vs   = 1'b1;
        end else begin
            if (m_vs && !vs) synced = 1'b1;
            m_hs = hs;
            m_vs = vs;
        end
    endtask

    // One full frame; optional short line and optional one-cycle reset.
    task automatic run_frame(input int short_line, input int rst_line);
        logic hs, vs, bl, rs;
        int   pos, vs_beg, vs_end;
        for (int ln = 0; ln < V_TOT; ln++) begin
            for (int h = 0; h < H_TOT; h++) begin
                hs = !(h >= HS_ST && h < HS_ST + HS_LEN);
                if (!vs_align) begin
                    vs = !(ln >= VS_LINE && ln < VS_LINE + VS_LEN);
                end else begin
                    pos    = ln * H_TOT + h;
                    vs_beg = (VS_LINE - 1) * H_TOT + HS_ST;
                    vs_end = (VS_LINE - 1 + VS_LEN) * H_TOT + HS_ST;
                    vs = !(pos >= vs_beg && pos < vs_end);
                end
                bl = (ln < ACT_V) && (h < ((ln == short_line) ? ACT_H - 1 : ACT_H));
                rs = (ln == rst_line) && (h == 10);
                tick(hs, vs, bl, h, ln, rs);
            end
        end
        frame_no++;
    endtask

    task automatic frame_end(input string tag, input logic exp_lock, input int exp_errs);
        check({tag, "_locked"}, 32'(locked), 32'(exp_lock));
        check({tag, "_errs"}, 32'(err_seen), 32'(exp_errs));
    endtask

    task automatic check_totals(input string tag);
        check({tag, "_h_total"}, 32'(h_total), 32'(H_TOT));
        check({tag, "_v_total"}, 32'(v_total), 32'(V_TOT));
    endtask

    initial begin
        // reset held for two clocks; the bench starts expecting reset values
        tick(1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);

        // nominal stream: lock at the third VS fall
        run_frame(-1, -1); frame_end("f1", 1'b0, 0);
        run_frame(-1, -1); frame_end("f2", 1'b0, 0);
        run_frame(-1, -1); frame_end("f3", 1'b1, 0);
        check_totals("f3");
        run_frame(-1, -1); frame_end("f4", 1'b1, 0);

        // one short line while locked: err pulse, relock two frames later
        run_frame(2, -1);  frame_end("short", 1'b0, 1);
        run_frame(-1, -1); frame_end("reacq1", 1'b0, 1);
        run_frame(-1, -1); frame_end("reacq2", 1'b1, 1);

        // VS falling together with HS
        vs_align = 1'b1;
        run_frame(-1, -1); frame_end("coinc1", 1'b1, 1);
        run_frame(-1, -1); frame_end("coinc2", 1'b1, 1);
        check_totals("coinc");
        vs_align = 1'b0;
        run_frame(-1, -1); frame_end("uncoinc", 1'b1, 1);

        // reset mid-frame
        run_frame(-1, 3);  frame_end("rst_f", 1'b0, 1);
        run_frame(-1, -1); frame_end("rst_r1", 1'b0, 1);
        run_frame(-1, -1); frame_end("rst_r2", 1'b1, 1);

        // HS stuck high long enough to saturate the line counter
        synced = 1'b0;
        for (int i = 0; i < 300; i++) tick(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        frame_end("stuck", 1'b0, 1);
        run_frame(-1, -1); frame_end("sync_r1", 1'b0, 1);
        run_frame(-1, -1); frame_end("sync_r2", 1'b0, 1);
        run_frame(-1, -1); frame_end("sync_r3", 1'b1, 1);
        check_totals("final");

        tick(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        check("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
